// File: rtl/random_draw_ctrl_if.sv
// Draw handshake between game logic, the random source and random_draw_ctrl.
// master: game logic plus source stub side; slave: the draw controller.
interface random_draw_ctrl_if #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 4
);
    logic                draw_req;
    logic [IN_BITS-1:0]  rnd_din;
    logic                rnd_rise;
    logic                draw_busy;
    logic                draw_valid;
    logic [OUT_BITS-1:0] draw_value;
    logic                draw_err;

    modport master (
        output draw_req, rnd_din,
        input  rnd_rise, draw_busy, draw_valid, draw_value, draw_err
    );

    modport slave (
        input  draw_req, rnd_din,
        output rnd_rise, draw_busy, draw_valid, draw_value, draw_err
    );
endinterface

// File: rtl/random_draw_ctrl.sv
// Rejection-sampling requester for a counter-latching random source.
// Optional RND_EXCLUDE_LAST_EN: also reject a repeat of the last accepted value.
//
// state | meaning
// IDLE  | waiting for draw_req
// RISE  | rnd_rise held high for SETTLE_CYC cycles, sample captured at the end
// CHECK | rnd_rise low; accept, retry or fall back
// DONE  | draw_valid pulse with new draw_value/draw_err
module random_draw_ctrl #(
    parameter int IN_BITS      = 8,
    parameter int OUT_BITS     = 4,
    parameter int RANGE        = 10,
    parameter int MAX_RETRY    = 7,
    parameter int SETTLE_CYC   = 2,
    parameter int FALLBACK_VAL = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    random_draw_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {S_IDLE, S_RISE, S_CHECK, S_DONE} state_t;

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int SW = $clog2(SETTLE_CYC);
    localparam logic [RW-1:0]       RETRY_MAX   = RW'(MAX_RETRY);
    localparam logic [SW-1:0]       SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [OUT_BITS:0]   RANGE_LIM   = (OUT_BITS + 1)'(RANGE);
    localparam logic [OUT_BITS-1:0] FALLBACK    = OUT_BITS'(FALLBACK_VAL);

    state_t              state;
    logic [RW-1:0]       retry_cnt;
    logic [SW-1:0]       settle_cnt;
    logic [OUT_BITS-1:0] cand;
    logic                in_range;
    logic                accept;

    // Extra bit so RANGE = 2**OUT_BITS accepts every candidate.
    assign in_range = ({1'b0, cand} < RANGE_LIM);

`ifdef RND_EXCLUDE_LAST_EN
    logic                have_last;
    logic [OUT_BITS-1:0] last_val;
    assign accept = in_range && !(have_last && (cand == last_val));
`else
    assign accept = in_range;
`endif

    generate
        if (IN_BITS > OUT_BITS) begin : g_hi
            logic unused_rnd_hi;
            assign unused_rnd_hi = ^bus.rnd_din[IN_BITS-1:OUT_BITS];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            retry_cnt       <= '0;
            settle_cnt      <= '0;
            cand            <= '0;
            bus.rnd_rise    <= 1'b0;
            bus.draw_busy   <= 1'b0;
            bus.draw_valid  <= 1'b0;
            bus.draw_value  <= '0;
            bus.draw_err    <= 1'b0;
`ifdef RND_EXCLUDE_LAST_EN
            have_last       <= 1'b0;
            last_val        <= '0;
`endif
        end else begin
            bus.draw_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.draw_req) begin
                        state         <= S_RISE;
                        settle_cnt    <= '0;
                        retry_cnt     <= '0;
                        bus.rnd_rise  <= 1'b1;
                        bus.draw_busy <= 1'b1;
                    end
                end
                S_RISE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        cand         <= bus.rnd_din[OUT_BITS-1:0];
                        bus.rnd_rise <= 1'b0;
                        state        <= S_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (accept) begin
                        bus.draw_value <= cand;
                        bus.draw_err   <= 1'b0;
                        bus.draw_valid <= 1'b1;
                        state          <= S_DONE;
`ifdef RND_EXCLUDE_LAST_EN
                        have_last      <= 1'b1;
                        last_val       <= cand;
`endif
                    end else if (retry_cnt == RETRY_MAX) begin
                        bus.draw_value <= FALLBACK;
                        bus.draw_err   <= 1'b1;
                        bus.draw_valid <= 1'b1;
                        state          <= S_DONE;
                    end else begin
                        // Re-arm from low so the source sees a fresh 0->1 edge.
                        retry_cnt    <= retry_cnt + 1'b1;
                        settle_cnt   <= '0;
                        bus.rnd_rise <= 1'b1;
                        state        <= S_RISE;
                    end
                end
                S_DONE: begin
                    bus.draw_busy <= 1'b0;
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_random_draw_ctrl.sv
// Scoreboard bench for random_draw_ctrl: directed cases plus random draws
// checked against a rejection-sampling reference model.
module tb_random_draw_ctrl;
    localparam int IN_BITS      = 8;
    localparam int OUT_BITS     = 4;
    localparam int RANGE        = 10;
    localparam int MAX_RETRY    = 7;
    localparam int SETTLE_CYC   = 2;
    localparam int FALLBACK_VAL = 0;
    localparam int ATT_LEN      = SETTLE_CYC + 1;

    typedef logic [IN_BITS-1:0] src_q_t[$];
    typedef struct {
        int cyc;
        int val;
        int err;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    random_draw_ctrl_if #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) bus ();

    random_draw_ctrl #(
        .IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .RANGE(RANGE),
        .MAX_RETRY(MAX_RETRY), .SETTLE_CYC(SETTLE_CYC), .FALLBACK_VAL(FALLBACK_VAL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int total = 0;
    int bad = 0;
    exp_t sb_q[$];
    logic [IN_BITS-1:0] stub_q[$];

    // Reference model state
    int win_start = -1;
    int win_att = 0;
    int end_cycle = -1;
    int held_val = 0;
    int held_err = 0;
    int m_have_last = 0;
    int m_last = 0;
    int n_drops = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at the negedge of the request cycle.
    task automatic model_draw(input src_q_t src);
        int att;
        int val;
        int err;
        int c;
        logic [IN_BITS-1:0] b;
        bit excl_en;
        exp_t e;
`ifdef RND_EXCLUDE_LAST_EN
        excl_en = 1'b1;
`else
        excl_en = 1'b0;
`endif
        if (cyc <= end_cycle) begin
            n_drops++;
            return;
        end
        att = MAX_RETRY + 1;
        val = FALLBACK_VAL;
        err = 1;
        for (int i = 0; i <= MAX_RETRY; i++) begin
            b = (i < src.size()) ? src[i] : 8'hFF;
            stub_q.push_back(b);
            c = int'(b) % (1 << OUT_BITS);
            if (c < RANGE && !(excl_en && m_have_last != 0 && c == m_last)) begin
                att = i + 1;
                val = c;
                err = 0;
                m_have_last = 1;
                m_last = c;
                break;
            end
        end
        e.cyc = cyc + att * ATT_LEN + 1;
        e.val = val;
        e.err = err;
        sb_q.push_back(e);
        win_start = cyc + 1;
        win_att = att;
        end_cycle = e.cyc;
    endtask

    task automatic issue(input src_q_t src);
        bus.draw_req = 1'b1;
        model_draw(src);
        @(negedge clk);
        bus.draw_req = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        sb_q.delete();
        stub_q.delete();
        end_cycle = -1;
        win_start = -1;
        win_att = 0;
        held_val = 0;
        held_err = 0;
        m_have_last = 0;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((cyc <= end_cycle || sb_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("idle_timeout", n, 0);
        @(negedge clk);
    endtask

    // Source stub: new sample on every 0->1 of rnd_rise.
    logic prev_rise = 1'b0;
    initial begin
        bus.rnd_din = '0;
        forever begin
            @(negedge clk);
            if (bus.rnd_rise && !prev_rise)
                bus.rnd_din = (stub_q.size() != 0) ? stub_q.pop_front() : 8'hFF;
            prev_rise = bus.rnd_rise;
        end
    end

    // Monitor: cycle-exact busy/rise, and scoreboard pop on draw_valid.
    initial begin
        int off;
        int busy_exp;
        int rise_exp;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                busy_exp = (cyc >= win_start && cyc <= end_cycle) ? 1 : 0;
                off = cyc - win_start;
                rise_exp = (busy_exp != 0 && off < win_att * ATT_LEN &&
                            (off % ATT_LEN) < SETTLE_CYC) ? 1 : 0;
                check("busy", int'(bus.draw_busy), busy_exp);
                check("rise", int'(bus.rnd_rise), rise_exp);
                if (bus.draw_valid) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_valid", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check("valid_cycle", cyc, e.cyc);
                        check("value", int'(bus.draw_value), e.val);
                        check("err", int'(bus.draw_err), e.err);
                        held_val = e.val;
                        held_err = e.err;
                    end
                end else begin
                    check("held_value", int'(bus.draw_value), held_val);
                    check("held_err", int'(bus.draw_err), held_err);
                end
            end
        end
    end

    initial begin
        src_q_t src;
        logic [IN_BITS-1:0] b;
        int gap;
        bit all_bad;

        bus.draw_req = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_valid", int'(bus.draw_valid), 0);
        check("rst_value", int'(bus.draw_value), 0);
        check("rst_err", int'(bus.draw_err), 0);
        check("rst_busy", int'(bus.draw_busy), 0);
        check("rst_rise", int'(bus.rnd_rise), 0);
        @(negedge clk);

        // Immediate accept
        src = {8'h03};
        issue(src);
        wait_idle();

        // Two rejects then accept
        src = {8'h0C, 8'h1F, 8'h05};
        issue(src);
        wait_idle();

        // Retries exhausted -> fallback with err
        src = {};
        for (int i = 0; i <= MAX_RETRY; i++) src.push_back(8'hFF);
        issue(src);
        wait_idle();

        // Range edge (10 rejected, 9 accepted) and ignored upper bits
        src = {8'hAA, 8'h39};
        issue(src);
        wait_idle();
        src = {8'hF3};
        issue(src);
        wait_idle();

        // Reset mid-RISE, then a fresh request
        src = {8'h03};
        issue(src);
        @(negedge clk);
        do_reset(1);
        @(negedge clk);
        @(negedge clk);
        issue(src);
        wait_idle();

        // Request while busy is dropped
        src = {8'h04};
        issue(src);
        @(negedge clk);
        issue(src);
        wait_idle();
        check("drop_seen", (n_drops > 0) ? 1 : 0, 1);

        // Repeat exclusion (only effective with RND_EXCLUDE_LAST_EN)
        src = {8'h07};
        issue(src);
        wait_idle();
        src = {8'h07, 8'h02};
        issue(src);
        wait_idle();

        for (int k = 0; k < 150; k++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            all_bad = ($urandom_range(0, 9) == 0);
            src = {};
            for (int i = 0; i <= MAX_RETRY; i++) begin
                b = IN_BITS'($urandom_range(0, 255));
                if (all_bad) b = (b & 8'hF0) | IN_BITS'(10 + $urandom_range(0, 5));
                src.push_back(b);
            end
            issue(src);
        end
        wait_idle();
        check("sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
